// File: rtl/j1_pkg.sv
// Shared definitions for the j1 memory loader: default geometry and FSM state encoding.
package j1_pkg;

  localparam int LOG2ABITS_DEF = 13;
  localparam int DWIDTH_DEF    = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    VERIFY = ST_VERIFY,
    RUN    = ST_RUN,
    ERROR  = ST_ERROR
  } state_e;

endpackage

// File: rtl/j1_mem_loader_if.sv
// Image stream and single RAM port seen by the j1 loader; slave is the loader side.
interface j1_mem_loader_if #(
  parameter int LOG2ABITS = 13,
  parameter int DWIDTH    = 16
) ();

  logic                 s_valid;
  logic                 s_ready;
  logic [DWIDTH-1:0]    s_data;
  logic                 s_last;
  logic                 mem_we;
  logic [LOG2ABITS-1:0] mem_addr;
  logic [DWIDTH-1:0]    mem_wdata;
  logic [DWIDTH-1:0]    mem_rdata;

  modport slave (
    input  s_valid, s_data, s_last, mem_rdata,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output s_valid, s_data, s_last, mem_rdata,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/j1_mem_loader.sv
// Streams a program image into the j1 RAM, reads it back to verify a modular sum,
// and releases cpu_reset only when the readback sum matches the written sum.
module j1_mem_loader
  import j1_pkg::*;
#(
  parameter int LOG2ABITS = LOG2ABITS_DEF,
  parameter int DWIDTH    = DWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  j1_mem_loader_if.slave       bus,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error,
  output logic [DWIDTH-1:0]    checksum,
  output logic [LOG2ABITS:0]   word_count
);

  localparam int CW = LOG2ABITS + 1;
  localparam logic [CW-1:0] LAST_IDX = {1'b0, {LOG2ABITS{1'b1}}};

  state_e               state_q, state_d;
  logic [CW-1:0]        addr_q, addr_d;
  logic [CW-1:0]        word_count_q, word_count_d;
  logic [DWIDTH-1:0]    checksum_q, checksum_d;
  logic [DWIDTH-1:0]    sum_q, sum_d;
  logic                 issue_q, issue_d;
  logic                 data_v_q, data_v_d;
  logic                 s_ready_q, s_ready_d;
  logic                 mem_we_q, mem_we_d;
  logic [LOG2ABITS-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 hs;

  assign hs = bus.s_valid & s_ready_q;

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips an assignment would infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    sum_d        = sum_q;
    issue_d      = 1'b0;
    data_v_d     = issue_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d      = LOAD;
          addr_d       = '0;
          word_count_d = '0;
          checksum_d   = '0;
        end
      end
      LOAD: begin
        if (hs) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q[LOG2ABITS-1:0];
          mem_wdata_d  = bus.s_data;
          checksum_d   = checksum_q + bus.s_data;
          word_count_d = word_count_q + CW'(1);
          addr_d       = addr_q + CW'(1);
          if (bus.s_last) begin
            state_d = VERIFY;
            addr_d  = '0;
            sum_d   = '0;
          end else if (word_count_q == LAST_IDX) begin
            // Final address written without s_last: stop rather than wrap to 0.
            state_d = ERROR;
          end
        end
      end
      VERIFY: begin
        // Read pipeline: issue_q marks a read address on the bus this cycle,
        // data_v_q marks that its data is on mem_rdata this cycle.
        if (addr_q < word_count_q) begin
          issue_d    = 1'b1;
          mem_addr_d = addr_q[LOG2ABITS-1:0];
          addr_d     = addr_q + CW'(1);
        end
        if (data_v_q) begin
          sum_d = sum_q + bus.mem_rdata;
          if (!issue_q) state_d = (sum_d == checksum_q) ? RUN : ERROR;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d   = (state_d == LOAD);
    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      sum_q        <= '0;
      issue_q      <= 1'b0;
      data_v_q     <= 1'b0;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      sum_q        <= sum_d;
      issue_q      <= issue_d;
      data_v_q     <= data_v_d;
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign error         = error_q;
  assign checksum      = checksum_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_j1_mem_loader.sv
// Randomized bench for j1_mem_loader: RAM model, write log and an image-level reference model.
module tb_j1_mem_loader;
  import j1_pkg::*;

  localparam int L  = 13;
  localparam int W  = 16;
  localparam int L8 = 3;

  logic clk = 1'b0;
  logic reset, start, start8;
  always #5 clk = ~clk;

  j1_mem_loader_if #(.LOG2ABITS(L),  .DWIDTH(W)) bus  ();
  j1_mem_loader_if #(.LOG2ABITS(L8), .DWIDTH(W)) bus8 ();

  logic         cpu_reset, done, error;
  logic [W-1:0] checksum;
  logic [L:0]   word_count;
  logic         cpu_reset8, done8, error8;
  logic [W-1:0] checksum8;
  logic [L8:0]  word_count8;

  j1_mem_loader #(.LOG2ABITS(L), .DWIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_reset(cpu_reset), .done(done), .error(error),
    .checksum(checksum), .word_count(word_count)
  );

  j1_mem_loader #(.LOG2ABITS(L8), .DWIDTH(W)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .bus(bus8),
    .cpu_reset(cpu_reset8), .done(done8), .error(error8),
    .checksum(checksum8), .word_count(word_count8)
  );

  // RAM models with one-cycle read latency; corrupt forces addr 2 to read 0x0004.
  logic [W-1:0] ram  [0:(1<<L)-1];
  logic [W-1:0] ram8 [0:(1<<L8)-1];
  bit corrupt = 1'b0;
  logic [L-1:0]  wa[$];
  logic [W-1:0]  wd[$];
  logic [L8-1:0] wa8[$];
  logic [W-1:0]  wd8[$];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    bus.mem_rdata <= (corrupt && bus.mem_addr == L'(2)) ? 16'h0004 : ram[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus8.mem_we) begin
      ram8[bus8.mem_addr] <= bus8.mem_wdata;
      wa8.push_back(bus8.mem_addr);
      wd8.push_back(bus8.mem_wdata);
    end
    bus8.mem_rdata <= ram8[bus8.mem_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] img_q[$];

  // Reference model: image sum mod 2^W, and pass unless the readback corruption changes the sum.
  function automatic logic [W-1:0] model_sum();
    logic [W-1:0] s = '0;
    foreach (img_q[i]) s += img_q[i];
    return s;
  endfunction

  function automatic bit model_pass();
    return !(corrupt && img_q.size() > 2 && img_q[2] != 16'h0004);
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    bus.s_valid = 1'b0;  bus.s_data = '0;  bus.s_last = 1'b0;
    bus8.s_valid = 1'b0; bus8.s_data = '0; bus8.s_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_load();
    wa.delete(); wd.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic stream_image(input int mode, input bit with_last);
    int idx = 0;
    int cyc = 0;
    while (idx < img_q.size() && cyc < 2000) begin
      bus.s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      bus.s_data  = img_q[idx];
      bus.s_last  = with_last && (idx == img_q.size() - 1);
      if (bus.s_valid && bus.s_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    checks++;
    if (idx !== img_q.size()) begin
      errors++;
      $display("FAIL stream_accept: accepted %0d words, required %0d", idx, img_q.size());
    end
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_timeout: done=%b error=%b, required done or error", name, done, error);
    end
  endtask

  task automatic check_load(input string name);
    bit pass = model_pass();
    checks++;
    if (wa.size() !== img_q.size()) begin
      errors++;
      $display("FAIL %s_wr_count: got %0d writes, required %0d", name, wa.size(), img_q.size());
    end
    for (int i = 0; i < wa.size() && i < img_q.size(); i++) begin
      checks++;
      if (wa[i] !== L'(i) || wd[i] !== img_q[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got addr %h data %h, required addr %h data %h",
                 name, i, wa[i], wd[i], L'(i), img_q[i]);
      end
    end
    checks++;
    if (checksum !== model_sum()) begin
      errors++;
      $display("FAIL %s_checksum: got %h, required %h", name, checksum, model_sum());
    end
    checks++;
    if (word_count !== (L+1)'(img_q.size())) begin
      errors++;
      $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, img_q.size());
    end
    checks++;
    if ({done, error, cpu_reset} !== {pass, !pass, !pass}) begin
      errors++;
      $display("FAIL %s_status: got done=%b error=%b cpu_reset=%b, required %b %b %b",
               name, done, error, cpu_reset, pass, !pass, !pass);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({cpu_reset, bus.s_ready, bus.mem_we, done, error} !== 5'b10000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || checksum !== '0 || word_count !== '0) begin
      errors++;
      $display("FAIL %s: got cpu_reset=%b s_ready=%b we=%b done=%b error=%b addr=%h wdata=%h sum=%h cnt=%0d, required 1 0 0 0 0 0 0 0 0",
               name, cpu_reset, bus.s_ready, bus.mem_we, done, error, bus.mem_addr,
               bus.mem_wdata, checksum, word_count);
    end
  endtask

  task automatic fill_random(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back(W'($urandom));
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_values("reset_values");
    checks++;
    if ({cpu_reset8, bus8.s_ready, done8, error8} !== 4'b1000 || word_count8 !== '0) begin
      errors++;
      $display("FAIL reset_values8: got cpu_reset=%b s_ready=%b done=%b error=%b cnt=%0d, required 1 0 0 0 0",
               cpu_reset8, bus8.s_ready, done8, error8, word_count8);
    end
  endtask

  task automatic test_basic();
    img_q = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
    corrupt = 1'b0;
    begin_load();
    stream_image(0, 1'b1);
    wait_end("basic");
    check_load("basic");
    checks++;
    if (checksum !== 16'h0005) begin
      errors++;
      $display("FAIL basic_sum_const: got %h, required 0005", checksum);
    end
  endtask

  task automatic test_corrupt();
    img_q = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
    corrupt = 1'b1;
    begin_load();
    stream_image(0, 1'b1);
    wait_end("corrupt");
    check_load("corrupt");
    corrupt = 1'b0;
  endtask

  task automatic test_toggle();
    fill_random(6 + int'($urandom_range(0, 10)));
    begin_load();
    stream_image(1, 1'b1);
    wait_end("toggle");
    check_load("toggle");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      fill_random(1 + int'($urandom_range(0, 40)));
      corrupt = ($urandom_range(0, 2) == 0);
      begin_load();
      stream_image(2, 1'b1);
      wait_end($sformatf("random%0d", it));
      check_load($sformatf("random%0d", it));
    end
    corrupt = 1'b0;
  endtask

  task automatic test_overflow();
    logic [W-1:0] img8[9];
    logic [W-1:0] sum8 = '0;
    int idx = 0;
    int n = 0;
    foreach (img8[i]) img8[i] = W'($urandom);
    for (int i = 0; i < 8; i++) sum8 += img8[i];
    wa8.delete(); wd8.delete();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < 9; cyc++) begin
      bus8.s_valid = 1'b1;
      bus8.s_data  = img8[idx];
      bus8.s_last  = 1'b0;
      if (bus8.s_ready) idx++;
      @(negedge clk);
    end
    bus8.s_valid = 1'b0;
    while (!error8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (idx !== 8 || wa8.size() !== 8) begin
      errors++;
      $display("FAIL ovf_count: accepted %0d writes %0d, required 8 8", idx, wa8.size());
    end
    for (int i = 0; i < wa8.size(); i++) begin
      checks++;
      if (wa8[i] !== L8'(i) || wd8[i] !== img8[i]) begin
        errors++;
        $display("FAIL ovf_write%0d: got addr %h data %h, required addr %h data %h",
                 i, wa8[i], wd8[i], L8'(i), img8[i]);
      end
    end
    checks++;
    if ({error8, cpu_reset8, done8} !== 3'b110 || word_count8 !== 4'd8 || checksum8 !== sum8) begin
      errors++;
      $display("FAIL ovf_status: got error=%b cpu_reset=%b done=%b cnt=%0d sum=%h, required 1 1 0 8 %h",
               error8, cpu_reset8, done8, word_count8, checksum8, sum8);
    end
  endtask

  task automatic test_reset_mid();
    fill_random(2);
    begin_load();
    stream_image(0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset_values");
    reset = 1'b0;
    @(negedge clk);
    fill_random(3);
    begin_load();
    stream_image(0, 1'b1);
    wait_end("after_reset");
    check_load("after_reset");
  endtask

  task automatic test_restart_run();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre: got done=%b, required 1", done);
    end
    begin_load();
    checks++;
    if ({cpu_reset, done} !== 2'b10 || word_count !== '0) begin
      errors++;
      $display("FAIL restart_clear: got cpu_reset=%b done=%b cnt=%0d, required 1 0 0",
               cpu_reset, done, word_count);
    end
    fill_random(5 + int'($urandom_range(0, 5)));
    stream_image(2, 1'b1);
    wait_end("restart");
    check_load("restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_toggle();
    test_random();
    test_overflow();
    test_reset_mid();
    test_restart_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
